cache_bank_sram: RTL and testbench
==================================

CACHE_BANK_SRAM -- requirements
Module: cache_bank_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the width of each stored word.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, giving the address width; depth = 2**ADDR_WIDTH entries.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port i_we, input, 1 bit: write enable.
REQ-006 SHALL have port i_wdata, input, DATA_WIDTH bits: write data.
REQ-007 SHALL have port i_waddr, input, ADDR_WIDTH bits: write address.
REQ-008 SHALL have port i_raddr, input, ADDR_WIDTH bits: read address.
REQ-009 SHALL have port o_rdata, output, DATA_WIDTH bits: registered read data.

Function
REQ-010 SHALL implement a simple dual-port memory: one write port and one read port, both usable in the same cycle.
REQ-011 SHALL write i_wdata to entry i_waddr at a rising clk edge when i_we=1 and rst_n=1; i_we=0 leaves all entries unchanged.
REQ-012 SHALL load o_rdata with entry i_raddr at every rising clk edge while rst_n=1, with read latency exactly 1 cycle and no read enable.
REQ-013 SHALL hold o_rdata stable between clock edges, independent of input changes.
REQ-014 Read-during-write to the same address SHALL return the old content, unless the bypass feature (REQ-022) is compiled in.
REQ-015 Read-during-write to different addresses SHALL return the addressed entry unaffected by the write.
REQ-016 Back-to-back writes to one address SHALL leave the last-written value.
REQ-017 Addresses SHALL cover all 2**ADDR_WIDTH entries, with no wrap-around or out-of-range case.
REQ-018 Parameter check: if DATA_WIDTH<1 or ADDR_WIDTH<1, the module SHALL instantiate the undefined module INVALID_CACHE_BANK_PARAM to force an elaboration error.

Reset
REQ-019 While rst_n=0, o_rdata SHALL be 0 immediately, without waiting for a clock edge.
REQ-020 Memory contents SHALL NOT be reset, so the array stays SRAM-inferable; entries hold their values through reset, and unwritten entries are undefined.
REQ-021 While rst_n=0, writes SHALL be ignored; the first read after deassertion completes at the first rising edge with rst_n=1.

Configuration
REQ-022 Macro CACHE_BANK_BYPASS_EN: when defined, a same-cycle write and read to the same address with i_we=1 SHALL return i_wdata in o_rdata at that edge (write-first); when undefined, behaviour is read-first per REQ-014.

Structure
REQ-023 SHALL need no shared-package typedefs; depth SHALL be a local constant derived from ADDR_WIDTH, and callers take DATA_WIDTH from the core-wide width constants.
REQ-024 SHALL be a leaf with no sub-modules; the cache instantiates one per data word and one per tag array.

Verification
REQ-025 Reset mid-operation: o_rdata=0xDEADBEEF, assert rst_n=0 between edges -> o_rdata=0 immediately; after release, entry 5 still reads its pre-reset value.
REQ-026 Write 0x12345678 to addr 3, then read addr 3 -> o_rdata=0x12345678 one edge after the read address is applied.
REQ-027 Same cycle: write 0xAAAA0000 to addr 7 (old 0x11111111) and read addr 7 -> 0x11111111 without the macro, 0xAAAA0000 with CACHE_BANK_BYPASS_EN; next edge -> 0xAAAA0000.
REQ-028 Same cycle: write 0x5 to addr 0 and read addr 63 (holding 0x9) -> o_rdata=0x9, then addr 0 reads 0x5.
REQ-029 i_we=0 with i_wdata=0xFFFFFFFF at addr 2 (holding 0x42) -> addr 2 still reads 0x42.
REQ-030 Fill all 64 entries with their index, then read 0..63 -> each returns its index at 1-cycle latency.

Source files
------------

// File: rtl/cache_bank_sram_pkg.sv
// Shared defaults and elaboration-time checks for cache_bank_sram.
// Only constants and a helper live here; the bank itself needs no typedefs.
package cache_bank_sram_pkg;

    localparam int CB_DATA_W = 32;
    localparam int CB_ADDR_W = 6;

    function automatic bit cb_params_ok(input int dw, input int aw);
        return (dw >= 1) && (aw >= 1);
    endfunction

endpackage

// File: rtl/cache_bank_sram.sv
// Simple dual-port SRAM bank: one write port, one registered read port.
// CACHE_BANK_BYPASS_EN selects write-first on same-address collisions.
module cache_bank_sram
    import cache_bank_sram_pkg::*;
#(
    parameter int DATA_WIDTH = CB_DATA_W,
    parameter int ADDR_WIDTH = CB_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    generate
        if (!cb_params_ok(DATA_WIDTH, ADDR_WIDTH)) begin : g_bad_param
            INVALID_CACHE_BANK_PARAM u_invalid ();
        end
    endgenerate

    // Array carries no reset so it maps onto a real SRAM macro.
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_rd_next;

    always_ff @(posedge clk) begin
        if (rst_n && i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

`ifdef CACHE_BANK_BYPASS_EN
    always_comb begin
        w_rd_next = r_mem[i_raddr];
        if (i_we && (i_waddr == i_raddr)) begin
            w_rd_next = i_wdata;
        end
    end
`else
    always_comb begin
        w_rd_next = r_mem[i_raddr];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rd_next;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: tb/tb_cache_bank_sram.sv
// Randomized and directed checks of cache_bank_sram against an array model.
// Define CACHE_BANK_BYPASS_EN for both bench and RTL to check write-first mode.
module tb_cache_bank_sram;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int N  = 64;

`ifdef CACHE_BANK_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          i_we    = 1'b0;
    logic [DW-1:0] i_wdata = '0;
    logic [AW-1:0] i_waddr = '0;
    logic [AW-1:0] i_raddr = '0;
    logic [DW-1:0] o_rdata;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] m_mem [N];
    bit            m_vld [N];
    logic [DW-1:0] m_rd;
    bit            m_known = 1'b0;

    always #5 clk = ~clk;

    cache_bank_sram #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_we   (i_we),
        .i_wdata(i_wdata),
        .i_waddr(i_waddr),
        .i_raddr(i_raddr),
        .o_rdata(o_rdata)
    );

    task automatic chk(input string nm, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: the entry read at an edge is the content before that edge,
    // except a same-address write with bypass returns the new data.
    task automatic cyc(input bit we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [AW-1:0] ra);
        i_we    = we;
        i_waddr = wa;
        i_wdata = wd;
        i_raddr = ra;
        @(posedge clk);
        if (rst_n) begin
            if (BYP && we && wa == ra) begin
                m_rd    = wd;
                m_known = 1'b1;
            end else begin
                m_rd    = m_mem[ra];
                m_known = m_vld[ra];
            end
            if (we) begin
                m_mem[wa] = wd;
                m_vld[wa] = 1'b1;
            end
        end else begin
            m_known = 1'b0;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) chk("reset_out", o_rdata, '0);
        else if (m_known) chk("model_rd", o_rdata, m_rd);
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [AW-1:0] a;
        logic [AW-1:0] b;

        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, '0);
        chk("reset_hold", o_rdata, 32'h0);
        rst_n = 1'b1;
        cyc(1'b0, '0, '0, '0);

        cyc(1'b1, 6'd3, 32'h12345678, 6'd0);
        cyc(1'b0, 6'd0, 32'h0, 6'd3);
        chk("wr_then_rd", o_rdata, 32'h12345678);

        cyc(1'b1, 6'd7, 32'h11111111, 6'd0);
        cyc(1'b1, 6'd7, 32'hAAAA0000, 6'd7);
        chk("rdw_same", o_rdata, BYP ? 32'hAAAA0000 : 32'h11111111);
        cyc(1'b0, 6'd0, 32'h0, 6'd7);
        chk("rdw_same_next", o_rdata, 32'hAAAA0000);

        cyc(1'b1, 6'd63, 32'h9, 6'd0);
        cyc(1'b1, 6'd0, 32'h5, 6'd63);
        chk("rdw_diff", o_rdata, 32'h9);
        cyc(1'b0, 6'd0, 32'h0, 6'd0);
        chk("rdw_diff_next", o_rdata, 32'h5);

        cyc(1'b1, 6'd2, 32'h42, 6'd0);
        cyc(1'b0, 6'd2, 32'hFFFFFFFF, 6'd2);
        chk("we_low_same", o_rdata, 32'h42);
        cyc(1'b0, 6'd0, 32'h0, 6'd2);
        chk("we_low_after", o_rdata, 32'h42);

        cyc(1'b1, 6'd4, 32'hCAFE0001, 6'd0);
        cyc(1'b1, 6'd4, 32'hCAFE0002, 6'd0);
        cyc(1'b0, 6'd0, 32'h0, 6'd4);
        chk("b2b_write", o_rdata, 32'hCAFE0002);

        for (int i = 0; i < N; i++) begin
            a = AW'(i);
            cyc(1'b1, a, DW'(i), 6'd0);
        end
        for (int i = 0; i < N; i++) begin
            a = AW'(i);
            cyc(1'b0, 6'd0, 32'h0, a);
            chk("fill_idx", o_rdata, DW'(i));
        end

        cyc(1'b1, 6'd5, 32'hDEADBEEF, 6'd0);
        cyc(1'b0, 6'd0, 32'h0, 6'd5);
        chk("pre_reset", o_rdata, 32'hDEADBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", o_rdata, 32'h0);
        cyc(1'b1, 6'd9, 32'h0BAD0BAD, 6'd9);
        cyc(1'b1, 6'd5, 32'h0BAD0BAD, 6'd5);
        rst_n = 1'b1;
        cyc(1'b0, 6'd0, 32'h0, 6'd5);
        chk("post_reset_e5", o_rdata, 32'hDEADBEEF);
        cyc(1'b0, 6'd0, 32'h0, 6'd9);
        chk("rst_write_ign", o_rdata, 32'h9);

        for (int i = 0; i < 2000; i++) begin
            a = AW'($urandom_range(0, N - 1));
            b = ($urandom_range(0, 3) == 0) ? a : AW'($urandom_range(0, N - 1));
            cyc(1'($urandom), a, DW'($urandom), b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
